dwa_shaper: RTL and testbench
=============================

Name: dwa_shaper

Overview:
- Data-weighted-averaging mismatch shaper placed directly downstream of the MASH 1-1 modulator in dsm_core.
- Consumes the signed multibit MASH code and converts it to a unary element-select vector driving N_ELEM nominally equal unit DAC cells.
- Rotates a start pointer so that element mismatch error is first-order noise-shaped.
- Registered output feeds the pin/upconverter stage; one clock domain (aclk).

Parameters:
- MASH_BW, 3, width of signed input code (two's complement).
- N_ELEM, 4, number of unit DAC elements; legal range 2..16, need not be a power of two.
- OFFSET, 1, added to the input code to form the element count (MASH 1-1 range -1..+2 maps to 0..3).
- PTR_W, $clog2(N_ELEM), derived pointer width; not overridden.

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- dwa_enable  in  1  1 = rotate pointer (DWA); 0 = static thermometer from element 0.
- in_valid  in  1  qualifies mash_data for this cycle.
- mash_data  in  MASH_BW  signed MASH output code.
- elem_out  out  N_ELEM  element selects; bit i drives element i.
- out_valid  out  1  elem_out updated this cycle.
- ptr  out  PTR_W  current rotation pointer (debug).
- sat_flag  out  1  sticky; set on any clamp event.
- sat_count  out  16  saturating count of clamp events.

Behaviour:
- Reset (rst=1 at edge): elem_out=0, out_valid=0, ptr=0, sat_flag=0, sat_count=0. Reset wins over in_valid. Reset mid-stream discards the in-flight sample; the first valid after release starts at ptr=0.
- Count arithmetic:
  - cnt = sign-extended mash_data + OFFSET, computed at MASH_BW+2 bits signed.
  - If cnt<0, clamp to 0. If cnt>N_ELEM, clamp to N_ELEM.
  - Any clamp with in_valid=1 is a clamp event.
- Latency: 1 cycle. A sample accepted at edge k appears on elem_out and out_valid=1 after edge k.
- When in_valid=0 at an edge: out_valid=0, elem_out and ptr hold, no clamp is counted.
- DWA mode (dwa_enable=1), per valid sample with clamped count c:
  - elem_out bit j=1 iff (j-ptr) mod N_ELEM < c.
  - ptr_next = (ptr+c) mod N_ELEM, computed without power-of-two wrap (compare/subtract).
  - c=0: elem_out=0, ptr holds. c=N_ELEM: all ones, ptr holds.
- Static mode (dwa_enable=0):
  - elem_out bits 0..c-1 set; ptr holds its value.
  - On a dwa_enable 0->1 change, rotation resumes from the held ptr.
- Clamp events: sat_flag set to 1 and held until rst. sat_count increments by 1 per event, saturates at 16'hFFFF (no wrap).
- popcount(elem_out) equals c on every out_valid cycle.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1, mash_data=2 -> all outputs 0 throughout.
- DWA, code 0 (c=1) for 5 valid cycles -> elem_out 0001, 0010, 0100, 1000, 0001; ptr 1, 2, 3, 0, 1.
- DWA, code +2 (c=3) from ptr=0 for 4 cycles -> 0111, 1011, 1101, 1110; ptr 3, 2, 1, 0. Over the 4 cycles each element is selected exactly 3 times.
- Boundaries:
  - code -1 -> elem_out 0000, ptr unchanged.
  - code +3 (c=4) -> 1111, ptr unchanged.
  - code -2 and -4 -> 0000, sat_flag=1, sat_count=2.
- Static mode: dwa_enable=0, code +1 (c=2) for 3 cycles -> 0011 each cycle, ptr frozen. Then dwa_enable=1 -> rotation starts at the frozen ptr.
- Gaps and reset: alternate in_valid 1/0 -> out_valid toggles and elem_out holds on gap cycles. Assert rst mid-sequence -> next valid code 0 gives 0001.

Source files
------------

// File: rtl/dwa_shaper.sv
// Data-weighted-averaging shaper: turns a signed MASH code into a rotating
// unary select vector so unit-element mismatch error is first-order shaped.
module dwa_shaper #(
    parameter int MASH_BW = 3,
    parameter int N_ELEM  = 4,
    parameter int OFFSET  = 1,
    parameter int PTR_W   = $clog2(N_ELEM)
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic                      dwa_enable,
    input  logic                      in_valid,
    input  logic signed [MASH_BW-1:0] mash_data,
    output logic        [N_ELEM-1:0]  elem_out,
    output logic                      out_valid,
    output logic        [PTR_W-1:0]   ptr,
    output logic                      sat_flag,
    output logic        [15:0]        sat_count
);

    localparam int CNT_W = MASH_BW + 2;

    logic signed [CNT_W-1:0] cnt;
    int                      c_sel;
    int                      ptr_i;
    int                      ptr_sum;
    logic                    clamp_hit;
    logic        [N_ELEM-1:0] mask;
    logic        [PTR_W-1:0]  ptr_next;

    // Element count: sign-extended code plus offset, clamped to 0..N_ELEM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cnt       = CNT_W'(mash_data) + CNT_W'(OFFSET);
        c_sel     = int'(cnt);
        clamp_hit = 1'b0;
        if (cnt < 0) begin
            c_sel     = 0;
            clamp_hit = 1'b1;
        end else if (int'(cnt) > N_ELEM) begin
            c_sel     = N_ELEM;
            clamp_hit = 1'b1;
        end
    end

    // Select window of c_sel elements starting at ptr, wrapping modulo N_ELEM;
    // static mode anchors the window at element 0.
    always_comb begin
        ptr_i   = int'(ptr);
        mask    = '0;
        ptr_sum = ptr_i + c_sel;
        for (int j = 0; j < N_ELEM; j++) begin
            if (!dwa_enable) begin
                mask[j] = (j < c_sel);
            end else if (j >= ptr_i) begin
                mask[j] = ((j - ptr_i) < c_sel);
            end else begin
                mask[j] = ((j + N_ELEM - ptr_i) < c_sel);
            end
        end
        // N_ELEM need not be a power of two, so wrap by compare/subtract.
        if (ptr_sum >= N_ELEM) begin
            ptr_sum = ptr_sum - N_ELEM;
        end
        ptr_next = PTR_W'(ptr_sum);
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            elem_out  <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (in_valid) begin
            elem_out  <= mask;
            out_valid <= 1'b1;
            if (dwa_enable) begin
                ptr <= ptr_next;
            end
            if (clamp_hit) begin
                sat_flag <= 1'b1;
                if (sat_count != 16'hFFFF) begin
                    sat_count <= sat_count + 16'd1;
                end
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dwa_shaper.sv
// Self-checking bench for dwa_shaper: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_dwa_shaper;

    localparam int MASH_BW = 3;
    localparam int N_ELEM  = 4;
    localparam int OFFSET  = 1;
    localparam int PTR_W   = 2;

    logic                      aclk = 1'b0;
    logic                      rst = 1'b1;
    logic                      dwa_enable = 1'b1;
    logic                      in_valid = 1'b0;
    logic signed [MASH_BW-1:0] mash_data = '0;
    logic        [N_ELEM-1:0]  elem_out;
    logic                      out_valid;
    logic        [PTR_W-1:0]   ptr;
    logic                      sat_flag;
    logic        [15:0]        sat_count;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [N_ELEM-1:0] m_elem = '0;
    logic              m_valid = 1'b0;
    int                m_ptr = 0;
    logic              m_flag = 1'b0;
    int                m_cnt = 0;

    typedef struct {
        logic              r;
        logic              e;
        logic              v;
        logic signed [2:0] code;
        logic [3:0]        elem;
        logic              ov;
        logic [1:0]        p;
        logic              flag;
        logic [15:0]       cnt;
    } vec_t;

    vec_t tbl[$];

    dwa_shaper #(.MASH_BW(MASH_BW), .N_ELEM(N_ELEM), .OFFSET(OFFSET)) dut (
        .aclk      (aclk),
        .rst       (rst),
        .dwa_enable(dwa_enable),
        .in_valid  (in_valid),
        .mash_data (mash_data),
        .elem_out  (elem_out),
        .out_valid (out_valid),
        .ptr       (ptr),
        .sat_flag  (sat_flag),
        .sat_count (sat_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: select c consecutive elements from the start position, modulo N.
    task automatic model_step(input logic r, input logic e, input logic v, input logic signed [2:0] code);
        int c;
        int start;
        if (r) begin
            m_elem = '0; m_valid = 1'b0; m_ptr = 0; m_flag = 1'b0; m_cnt = 0;
        end else if (v) begin
            c = int'(code) + OFFSET;
            if (c < 0 || c > N_ELEM) begin
                m_flag = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (c < 0) c = 0;
            if (c > N_ELEM) c = N_ELEM;
            start = e ? m_ptr : 0;
            m_elem = '0;
            for (int k = 0; k < c; k++) m_elem[(start + k) % N_ELEM] = 1'b1;
            if (e) m_ptr = (m_ptr + c) % N_ELEM;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic signed [2:0] code);
        @(negedge aclk);
        rst = r; dwa_enable = e; in_valid = v; mash_data = code;
        @(posedge aclk);
        #1;
        model_step(r, e, v, code);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic v, input int code,
                                input logic [3:0] elem, input logic ov, input logic [1:0] p,
                                input logic flag, input logic [15:0] cnt);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.code = 3'(code);
        t.elem = elem; t.ov = ov; t.p = p; t.flag = flag; t.cnt = cnt;
        return t;
    endfunction

    initial begin
        // Reset held with valid traffic present
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 2, 4'b0000, 0, 0, 0, 0));
        // DWA, c=1 walks one element at a time
        tbl.push_back(mk(0, 1, 1, 0, 4'b0001, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0010, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0100, 1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'b1000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0001, 1, 1, 0, 0));
        // Reset back to ptr=0, then c=3 rotation
        tbl.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2, 4'b0111, 1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2, 4'b1011, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2, 4'b1101, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2, 4'b1110, 1, 0, 0, 0));
        // Boundaries: c=0, c=N, then two clamp events
        tbl.push_back(mk(0, 1, 1, -1, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  3, 4'b1111, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, -2, 4'b0000, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, -4, 4'b0000, 1, 0, 1, 2));
        // Move ptr off zero, freeze it in static mode, then resume rotation
        tbl.push_back(mk(0, 1, 1, 0, 4'b0001, 1, 1, 1, 2));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 1, 4'b0011, 1, 1, 1, 2));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0010, 1, 2, 1, 2));
        // Gaps: outputs hold, clamp-worthy code ignored while invalid
        tbl.push_back(mk(0, 1, 1, 0, 4'b0100, 1, 3, 1, 2));
        tbl.push_back(mk(0, 1, 0, -4, 4'b0100, 0, 3, 1, 2));
        tbl.push_back(mk(0, 1, 1, 1, 4'b1001, 1, 1, 1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 4'b1001, 0, 1, 1, 2));
        // Mid-stream reset, first valid restarts from element 0
        tbl.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 4'b0001, 1, 1, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].code);
            check($sformatf("vec%0d_elem", i), 32'(elem_out), 32'(tbl[i].elem));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(tbl[i].p));
            check($sformatf("vec%0d_flag", i), 32'(sat_flag), 32'(tbl[i].flag));
            check($sformatf("vec%0d_cnt", i), 32'(sat_count), 32'(tbl[i].cnt));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic r, e, v;
            logic signed [2:0] code;
            int ones;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 4) != 0);
            v = ($urandom_range(0, 3) != 0);
            code = 3'($urandom_range(0, 7));
            drive(r, e, v, code);
            check("rand_elem", 32'(elem_out), 32'(m_elem));
            check("rand_valid", 32'(out_valid), 32'(m_valid));
            check("rand_ptr", 32'(ptr), 32'(m_ptr));
            check("rand_flag", 32'(sat_flag), 32'(m_flag));
            check("rand_cnt", 32'(sat_count), 32'(m_cnt));
            if (m_valid) begin
                ones = 0;
                for (int k = 0; k < N_ELEM; k++) ones += int'(elem_out[k]);
                if (!r && v) begin
                    int c;
                    c = int'(code) + OFFSET;
                    if (c < 0) c = 0;
                    if (c > N_ELEM) c = N_ELEM;
                    check("rand_popcount", 32'(ones), 32'(c));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
